// File: rtl/arb_memory_pkg.sv
// arb_memory_pkg: shared constants, width helpers and the
// read/write pipeline stage type for the arbitrated memory.
package arb_memory_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;
  localparam int CH_MAX = 8;

  // Stage fields are sized for the widest supported
  // configuration; narrower instances use the low bits.
  localparam int STG_ID_W = 3;
  localparam int STG_DATA_W = 128;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int mask_w(input int dw);
    return dw / 8;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [STG_ID_W-1:0]   ch_id;
    logic                  is_read;
    logic [STG_DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over NUM_CH requests.
// Ports: clk, rst, request, advance in; grant, pointer out.
module rr_arbiter
  import arb_memory_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int IDX_W = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] request,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  pointer
);

  logic [IDX_W-1:0] pick;
  int c;

  // Walk from the far end back toward the pointer so the
  // nearest requester at or after the pointer wins last.
  always_comb begin
    grant = '0;
    pick = pointer;
    c = 0;
    if (!rst) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        c = (int'(pointer) + k) % NUM_CH;
        if (request[c]) begin
          grant = '0;
          grant[c] = 1'b1;
          pick = IDX_W'(c);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pointer <= '0;
    end else if (advance) begin
      if (int'(pick) + 1 == NUM_CH) begin
        pointer <= '0;
      end else begin
        pointer <= pick + 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_memory.sv
// arb_memory: NUM_CH requestors share one word array via a
// round-robin arbiter, byte-masked writes and a LATENCY-deep
// completion pipeline. Ports: clk, rst, ch_request, ch_we_re,
// ch_address, ch_data_in, ch_mask in; ch_grant, ch_valid,
// ch_data_out out (channel c at slice c of each bus).
module arb_memory
  import arb_memory_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_request,
  input  logic [NUM_CH-1:0]          ch_we_re,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_in,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_mask,
  output logic [NUM_CH-1:0]          ch_grant,
  output logic [NUM_CH-1:0]          ch_valid,
  output logic [NUM_CH*DATA_W-1:0]   ch_data_out
);

  localparam int MASK_W = mask_w(DATA_W);
  localparam int IDX_W = ch_idx_w(NUM_CH);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LAT = (LATENCY < LAT_MIN) ? LAT_MIN :
                       (LATENCY > LAT_MAX) ? LAT_MAX :
                       LATENCY;

  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  rr_ptr;
  logic              accept;
  logic [IDX_W-1:0]  sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [MASK_W-1:0] wmask;
  logic              wr;
  logic [DATA_W-1:0] mem [DEPTH];
  stage_t            stage_in;
  stage_t            tail;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .clk(clk),
    .rst(rst),
    .request(ch_request),
    .advance(accept),
    .grant(grant),
    .pointer(rr_ptr)
  );

  assign ch_grant = grant;
  assign accept = |(ch_request & grant);

  always_comb begin
    sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) sel = IDX_W'(c);
    end
  end

  assign addr  = ch_address[int'(sel)*ADDR_W +: ADDR_W];
  assign wdata = ch_data_in[int'(sel)*DATA_W +: DATA_W];
  assign wmask = ch_mask[int'(sel)*MASK_W +: MASK_W];
  assign wr    = ch_we_re[sel];

  // Array is not reset; rst blocks grants, so no writes occur.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (wmask[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read data is sampled at the accept edge, before the
  // non-blocking write above could land.
  always_comb begin
    stage_in = '0;
    stage_in.valid = accept;
    stage_in.ch_id = STG_ID_W'(sel);
    stage_in.is_read = !wr;
    stage_in.data = STG_DATA_W'(mem[addr]);
  end

  if (LAT > 1) begin : g_pipe
    stage_t pipe [LAT-1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= stage_in;
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign tail = pipe[LAT-2];
  end else begin : g_direct
    assign tail = stage_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_valid <= '0;
      ch_data_out <= '0;
    end else begin
      ch_valid <= '0;
      if (tail.valid) begin
        ch_valid[tail.ch_id[IDX_W-1:0]] <= 1'b1;
        if (tail.is_read) begin
          ch_data_out[int'(tail.ch_id[IDX_W-1:0])*DATA_W +: DATA_W]
            <= tail.data[DATA_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_arb_memory.sv
// tb_arb_memory: drives a LATENCY=1 and a LATENCY=3 instance
// and checks them against a transaction-level model.
module tb_arb_memory;

  localparam int NC = 2;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_v [2];
  logic [NC-1:0]  req   [2];
  logic [NC-1:0]  we    [2];
  logic [AW-1:0]  addr  [2][NC];
  logic [DW-1:0]  wdat  [2][NC];
  logic [MW-1:0]  msk   [2][NC];
  logic [NC*AW-1:0] a_p [2];
  logic [NC*DW-1:0] d_p [2];
  logic [NC*MW-1:0] m_p [2];
  logic [NC-1:0]  gnt   [2];
  logic [NC-1:0]  vld   [2];
  logic [NC*DW-1:0] dout [2];

  for (genvar d = 0; d < 2; d++) begin : g_pk
    assign a_p[d] = {addr[d][1], addr[d][0]};
    assign d_p[d] = {wdat[d][1], wdat[d][0]};
    assign m_p[d] = {msk[d][1], msk[d][0]};
  end

  arb_memory #(
    .NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .LATENCY(1)
  ) u_l1 (
    .clk(clk), .rst(rst_v[0]),
    .ch_request(req[0]), .ch_we_re(we[0]),
    .ch_address(a_p[0]), .ch_data_in(d_p[0]),
    .ch_mask(m_p[0]), .ch_grant(gnt[0]),
    .ch_valid(vld[0]), .ch_data_out(dout[0])
  );

  arb_memory #(
    .NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .LATENCY(3)
  ) u_l3 (
    .clk(clk), .rst(rst_v[1]),
    .ch_request(req[1]), .ch_we_re(we[1]),
    .ch_address(a_p[1]), .ch_data_in(d_p[1]),
    .ch_mask(m_p[1]), .ch_grant(gnt[1]),
    .ch_valid(vld[1]), .ch_data_out(dout[1])
  );

  // ---------------- reference model ----------------
  typedef struct {
    int d;
    int due;
    int ch;
    bit rd;
    logic [DW-1:0] data;
  } pend_t;

  pend_t         pq [$];
  logic [DW-1:0] mm [2][256];
  int            mptr [2];
  logic [NC-1:0] e_vld [2];
  logic [DW-1:0] e_dout [2][NC];
  logic [NC-1:0] g_seen [2];
  int edge_n = 0;
  int n_chk = 0;
  int n_fail = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [DW-1:0] hash(input int a);
    return DW'(a) * 32'h0101_0101 ^ 32'hA5C3_0F96;
  endfunction

  function automatic int pick(input int d);
    int c;
    for (int k = 0; k < NC; k++) begin
      c = (mptr[d] + k) % NC;
      if (req[d][c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_edge(input int d, input int g);
    pend_t p;
    logic [DW-1:0] w;
    int i;
    e_vld[d] = '0;
    if (rst_v[d]) begin
      i = 0;
      while (i < pq.size()) begin
        if (pq[i].d == d) pq.delete(i);
        else i++;
      end
      mptr[d] = 0;
      for (int c = 0; c < NC; c++) e_dout[d][c] = '0;
      return;
    end
    if (g >= 0) begin
      w = mm[d][addr[d][g]];
      p.d = d;
      p.due = edge_n + lat(d) - 1;
      p.ch = g;
      p.rd = !we[d][g];
      p.data = w;
      pq.push_back(p);
      if (we[d][g]) begin
        for (int b = 0; b < MW; b++)
          if (msk[d][g][b]) w[b*8 +: 8] = wdat[d][g][b*8 +: 8];
        mm[d][addr[d][g]] = w;
      end
      mptr[d] = (g + 1) % NC;
    end
    i = 0;
    while (i < pq.size()) begin
      if (pq[i].d == d && pq[i].due == edge_n) begin
        e_vld[d][pq[i].ch] = 1'b1;
        if (pq[i].rd) e_dout[d][pq[i].ch] = pq[i].data;
        pq.delete(i);
      end else begin
        i++;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: check grants, clock edge, model, check outputs.
  task automatic tick();
    int g [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d] = rst_v[d] ? -1 : pick(d);
      chk($sformatf("grant_d%0d", d), 64'(gnt[d]),
          (g[d] >= 0) ? (64'(1) << g[d]) : 64'(0));
      g_seen[d] = gnt[d];
    end
    @(posedge clk);
    edge_n++;
    for (int d = 0; d < 2; d++) model_edge(d, g[d]);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("valid_d%0d", d), 64'(vld[d]), 64'(e_vld[d]));
      for (int c = 0; c < NC; c++)
        chk($sformatf("dout_d%0d_c%0d", d, c),
            64'(dout[d][c*DW +: DW]), 64'(e_dout[d][c]));
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) req[d] = '0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  rq;
    logic [1:0]  wr;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [3:0]  m0;
    logic [3:0]  m1;
    logic [1:0]  eg;
    logic [1:0]  ev;
    logic [31:0] eo0;
    logic [31:0] eo1;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{2'b01, 2'b01, 8'd5, 8'd0, 32'hDEADBEEF, 32'h0,
                4'hF, 4'h0, 2'b01, 2'b01, 32'h0, 32'h0};
    tbl[1]  = '{2'b01, 2'b00, 8'd5, 8'd0, 32'h0, 32'h0,
                4'h0, 4'h0, 2'b01, 2'b01, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{2'b01, 2'b01, 8'd7, 8'd0, 32'h11223344, 32'h0,
                4'hF, 4'h0, 2'b01, 2'b01, 32'hDEADBEEF, 32'h0};
    tbl[3]  = '{2'b01, 2'b01, 8'd7, 8'd0, 32'hAABBCCDD, 32'h0,
                4'h5, 4'h0, 2'b01, 2'b01, 32'hDEADBEEF, 32'h0};
    tbl[4]  = '{2'b01, 2'b00, 8'd7, 8'd0, 32'h0, 32'h0,
                4'h0, 4'h0, 2'b01, 2'b01, 32'h11BB33DD, 32'h0};
    tbl[5]  = '{2'b00, 2'b00, 8'd0, 8'd0, 32'h0, 32'h0,
                4'h0, 4'h0, 2'b00, 2'b00, 32'h11BB33DD, 32'h0};
    tbl[6]  = '{2'b10, 2'b00, 8'd0, 8'd5, 32'h0, 32'h0,
                4'h0, 4'h0, 2'b10, 2'b10, 32'h11BB33DD, 32'hDEADBEEF};
    tbl[7]  = '{2'b10, 2'b10, 8'd0, 8'd5, 32'h0, 32'h0,
                4'h0, 4'h0, 2'b10, 2'b10, 32'h11BB33DD, 32'hDEADBEEF};
    tbl[8]  = '{2'b10, 2'b00, 8'd0, 8'd5, 32'h0, 32'h0,
                4'h0, 4'h0, 2'b10, 2'b10, 32'h11BB33DD, 32'hDEADBEEF};
    for (int i = 9; i < 15; i++) begin
      tbl[i] = '{2'b11, 2'b00, 8'd7, 8'd5, 32'h0, 32'h0,
                 4'h0, 4'h0,
                 (i % 2 == 1) ? 2'b01 : 2'b10,
                 (i % 2 == 1) ? 2'b01 : 2'b10,
                 32'h11BB33DD, 32'hDEADBEEF};
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1;
      req[d] = 2'b11;
      we[d] = '0;
      mptr[d] = 0;
      e_vld[d] = '0;
      g_seen[d] = '0;
      for (int c = 0; c < NC; c++) begin
        addr[d][c] = '0;
        wdat[d][c] = '0;
        msk[d][c] = '0;
        e_dout[d][c] = '0;
      end
    end

    // Reset held 3 cycles with both channels requesting.
    repeat (3) tick();
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // Preload every word through channel 0.
    for (int a = 0; a < 256; a++) begin
      for (int d = 0; d < 2; d++) begin
        req[d] = 2'b01;
        we[d] = 2'b01;
        addr[d][0] = AW'(a);
        wdat[d][0] = hash(a);
        msk[d][0] = 4'hF;
      end
      tick();
    end
    idle_all();
    tick();

    // Directed table on the LATENCY=1 instance.
    foreach (tbl[i]) begin
      req[0] = tbl[i].rq;
      we[0] = tbl[i].wr;
      addr[0][0] = tbl[i].a0;
      addr[0][1] = tbl[i].a1;
      wdat[0][0] = tbl[i].d0;
      wdat[0][1] = tbl[i].d1;
      msk[0][0] = tbl[i].m0;
      msk[0][1] = tbl[i].m1;
      tick();
      chk($sformatf("tbl%0d_grant", i), 64'(g_seen[0]), 64'(tbl[i].eg));
      chk($sformatf("tbl%0d_valid", i), 64'(vld[0]), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_dout0", i), 64'(dout[0][31:0]),
          64'(tbl[i].eo0));
      chk($sformatf("tbl%0d_dout1", i), 64'(dout[0][63:32]),
          64'(tbl[i].eo1));
    end
    idle_all();
    tick();

    // Back-to-back reads on the LATENCY=3 instance.
    req[1] = 2'b10;
    we[1] = 2'b00;
    for (int a = 1; a <= 3; a++) begin
      addr[1][1] = AW'(a);
      tick();
      if (a < 3) chk($sformatf("pipe_pre%0d", a), 64'(vld[1]), 64'(0));
    end
    chk("pipe_v1", 64'(vld[1]), 64'(2'b10));
    chk("pipe_d1", 64'(dout[1][63:32]), 64'(hash(1)));
    req[1] = 2'b00;
    tick();
    chk("pipe_v2", 64'(vld[1]), 64'(2'b10));
    chk("pipe_d2", 64'(dout[1][63:32]), 64'(hash(2)));
    tick();
    chk("pipe_v3", 64'(vld[1]), 64'(2'b10));
    chk("pipe_d3", 64'(dout[1][63:32]), 64'(hash(3)));
    tick();
    chk("pipe_end", 64'(vld[1]), 64'(0));

    // Reset one cycle after a read is accepted.
    req[1] = 2'b10;
    addr[1][1] = 8'd9;
    tick();
    rst_v[1] = 1'b1;
    tick();
    chk("rst_grant", 64'(g_seen[1]), 64'(0));
    rst_v[1] = 1'b0;
    tick();
    chk("rst_drop_v", 64'(vld[1]), 64'(0));
    chk("rst_dout", 64'(dout[1]), 64'(0));
    req[1] = 2'b00;
    tick();
    chk("rst_drop_v2", 64'(vld[1]), 64'(0));
    tick();
    chk("rst_reread_v", 64'(vld[1]), 64'(2'b10));
    chk("rst_reread_d", 64'(dout[1][63:32]), 64'(hash(9)));

    // Random traffic; a request holds until it is granted.
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NC; c++) begin
          if (!req[d][c] || g_seen[d][c]) begin
            req[d][c] = ($urandom_range(3) != 0);
            we[d][c] = 1'($urandom_range(1));
            addr[d][c] = AW'($urandom_range(15));
            wdat[d][c] = $urandom;
            msk[d][c] = MW'($urandom_range(15));
          end
        end
      end
      tick();
    end
    idle_all();
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
